// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU data-path store buffer: request sizes, the
// buffered store entry layout and the buffer control states.
package cpu_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } store_entry_t;

    localparam int STORE_ENTRY_W = $bits(store_entry_t);

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } buf_state_t;

endpackage

// File: rtl/sbuf_fifo.sv
// Generic synchronous circular FIFO with registered pointers and occupancy
// count; the head entry is always visible without a pop.
module sbuf_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 66,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = storage_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/data_store_buffer.sv
// Posted-write buffer between the core data port and the AXI bridge data port.
// Stores ack one cycle after acceptance and drain in order; loads wait for all stores.
module data_store_buffer
    import cpu_mem_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    buf_state_t     state_q, state_d;
    logic [PTR_W:0] inflight_q, inflight_d;
    logic           ack_q, ack_d;

    store_entry_t   push_entry;
    store_entry_t   head_entry;
    logic [STORE_ENTRY_W-1:0] head_bits;
    logic [PTR_W:0] fifo_count;
    logic           fifo_full;
    logic           fifo_empty;

    logic           store_accept;
    logic           load_pass;
    logic           drain;
    logic           inflight_inc;
    logic           inflight_dec;

    assign push_entry = '{size: cpu_size, addr: cpu_addr, wdata: cpu_wdata};
    assign head_entry = store_entry_t'(head_bits);

    sbuf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (STORE_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (store_accept),
        .push_data (push_entry),
        .pop       (drain & mem_addr_ok),
        .head      (head_bits),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Port arbitration: a pending drain owns the bridge; a load only goes out
    // once nothing is buffered or in flight. Everything reads as 0 during reset.
    always_comb begin
        store_accept = 1'b0;
        load_pass    = 1'b0;
        drain        = 1'b0;
        cpu_addr_ok  = 1'b0;
        cpu_data_ok  = 1'b0;
        cpu_rdata    = '0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (!reset) begin
            cpu_data_ok = ack_q;
            case (state_q)
                IDLE: begin
                    drain        = ~fifo_empty;
                    store_accept = cpu_req & cpu_wr & ~fifo_full;
                    load_pass    = cpu_req & ~cpu_wr & (fifo_count == '0) &
                                   (inflight_q == '0);
                    if (drain) begin
                        mem_req   = 1'b1;
                        mem_wr    = 1'b1;
                        mem_size  = head_entry.size;
                        mem_addr  = head_entry.addr;
                        mem_wdata = head_entry.wdata;
                    end else if (load_pass) begin
                        mem_req   = 1'b1;
                        mem_size  = cpu_size;
                        mem_addr  = cpu_addr;
                    end
                    cpu_addr_ok = store_accept | (load_pass & mem_addr_ok);
                end
                LOAD_WAIT: begin
                    cpu_rdata   = mem_rdata;
                    cpu_data_ok = ack_q | mem_data_ok;
                end
                default: begin
                    cpu_addr_ok = 1'b0;
                end
            endcase
        end
    end

    // A mem_data_ok in IDLE with nothing in flight is ignored so the count never wraps.
    always_comb begin
        inflight_inc = drain & mem_addr_ok;
        inflight_dec = (state_q == IDLE) & mem_data_ok & (inflight_q != '0);
        case ({inflight_inc, inflight_dec})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
        ack_d   = store_accept;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load_pass & mem_addr_ok) begin
                    state_d = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (mem_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            inflight_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            ack_q      <= ack_d;
        end
    end

endmodule

// File: doc/data_store_buffer.md
Name: data_store_buffer

Overview:
Posted-write buffer on the CPU data path. It sits between the CPU core's SRAM-like data port and the data port of the AXI bridge. Stores complete to the core one cycle after acceptance and drain to memory in order in the background. Loads pass straight through, but only once every buffered and in-flight store has completed, so memory ordering is preserved.

Parameters:
DEPTH, 4, number of store entries; power of two, 2..16
PTR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridden)

Ports:
clk  in  1  core clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  core request valid
cpu_wr  in  1  1 = store, 0 = load
cpu_size  in  2  00 byte, 01 half, 10 word
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, lane-aligned as the core drives it
cpu_rdata  out  32  load data; valid when cpu_data_ok=1
cpu_addr_ok  out  1  request accepted this cycle (req & addr_ok)
cpu_data_ok  out  1  one pulse per accepted request, returned in order
mem_req  out  1  request to the bridge
mem_wr  out  1  request type to the bridge
mem_size  out  2  request size to the bridge
mem_addr  out  32  request address to the bridge
mem_wdata  out  32  store data to the bridge
mem_rdata  in  32  read data from the bridge
mem_addr_ok  in  1  bridge accepted the request
mem_data_ok  in  1  bridge completed the oldest outstanding request

Behaviour:
- Reset: while reset=1, the FIFO is emptied (buffered stores are discarded), wr_inflight=0, the state returns to IDLE, and the store-ack register clears. All outputs are forced to 0 (cpu_rdata=0, mem_* = 0), including the combinational outputs.
- Entry: {size[1:0], addr[31:0], wdata[31:0]}. The FIFO is a circular buffer; pointers wrap at DEPTH; count is PTR_W+1 bits.
- wr_inflight counter: PTR_W+1 bits.
  - Increments on a store handshake with the bridge (mem_req & mem_wr & mem_addr_ok).
  - Decrements on mem_data_ok while in IDLE.
  - Increment and decrement in the same cycle leave it unchanged.
- States:
  - IDLE.
  - LOAD_WAIT: one load is outstanding at the bridge.
- Store accept: cpu_addr_ok=1 when cpu_req & cpu_wr & state==IDLE & count<DEPTH.
  - The entry is pushed at that clock edge.
  - cpu_data_ok pulses exactly on the next cycle, from a register.
  - When full, the store is refused, even if a pop happens in the same cycle.
- Drain: in IDLE, when count>0, drive mem_req=1, mem_wr=1 and the head entry on mem_size/mem_addr/mem_wdata. mem_addr_ok pops the head.
- Load accept: a load passes through only when state==IDLE & count==0 & wr_inflight==0 & cpu_req & !cpu_wr.
  - Pass-through drives mem_req=1, mem_wr=0, mem_size=cpu_size, mem_addr=cpu_addr.
  - cpu_addr_ok = mem_addr_ok in that cycle.
  - The handshake moves the state to LOAD_WAIT.
  - If the pass-through conditions do not hold, cpu_addr_ok=0 and the core holds the request.
- Drain priority: a pending drain always wins the mem port over a load. No new store is accepted while a load waits behind the drain.
- LOAD_WAIT:
  - mem_req=0 and cpu_addr_ok=0.
  - cpu_rdata = mem_rdata and cpu_data_ok = mem_data_ok (combinational).
  - mem_data_ok returns the state to IDLE.
- Store data_ok vs load data_ok: they never coincide. A load is accepted only with the FIFO empty and the store-ack register clear, because the ack follows its acceptance by exactly one cycle.
- Ordering:
  - Stores reach the bridge in acceptance order.
  - A load reaches the bridge only after every earlier store's mem_data_ok.
- mem_data_ok in IDLE with wr_inflight==0 is a protocol error. It is ignored; the counter does not underflow. The bench asserts it never occurs.

Decomposition:
- Shared package cpu_mem_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD constants, the store-entry typedef, and the state enum {IDLE, LOAD_WAIT}.
- One sub-module, sbuf_fifo: a generic synchronous FIFO (push, pop, head, count, full, empty) parameterised by DEPTH and entry width.

Test Plan:
- Reset mid-operation: 3 stores buffered, assert reset for 1 cycle -> count=0, all outputs 0, no further mem_req.
- Back-to-back stores: 4 word stores to 0x100..0x10C with mem_addr_ok held 0 -> cpu_addr_ok on 4 cycles, 4 cpu_data_ok pulses each 1 cycle later. A 5th store gets cpu_addr_ok=0 until the first pop.
- Drain order: release mem_addr_ok=1 and return mem_data_ok 2 cycles after each -> mem_addr sequence 0x100, 0x104, 0x108, 0x10C with matching wdata/size.
- Load after store (RAW): store 0xDEADBEEF to 0x200, then load 0x200 -> the load's mem_req is issued only after the store's mem_data_ok. mem_rdata=0xDEADBEEF appears on cpu_rdata with cpu_data_ok in the same cycle.
- Load into empty buffer: load byte 0x303 with mem_addr_ok=1 -> mem_req, mem_wr=0, mem_size=00 in the same cycle; LOAD_WAIT entered. A store presented in LOAD_WAIT sees cpu_addr_ok=0 until mem_data_ok.
- Full with simultaneous pop: DEPTH entries, head pops while cpu_req=1 store -> store refused that cycle, accepted the next cycle, count stays DEPTH.
